mem_access_unit: RTL

Pipeline MEM-stage controller that consumes the effective address and the 2-bit misalignment flags produced by the address generation unit and performs the load or store against data memory. It generates byte enables, sign- or zero-extends load data, and reports misalignment and bus-timeout exceptions. It sits between the EX stage, which provides the AGU result and the store operand, and the write-back stage. It stalls the pipeline while a memory transaction is outstanding.

---
 rtl/mem_access_pkg.sv | 47 ++++
 rtl/mem_load_align.sv | 34 +++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the MEM-stage access unit.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] EXC_NONE           = 2'b00;
    localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'b01;
    localparam logic [1:0] EXC_STORE_MISALIGN = 2'b10;
    localparam logic [1:0] EXC_BUS_TIMEOUT    = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;

    // Byte accesses can never be misaligned; size 11 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] flags);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = flags[0];
            default:   mis = flags[1];
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr;
            SIZE_HALF: be = 4'b0011 << {addr[1], 1'b0};
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand into every lane so the byte enables pick the target.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{data[7:0]}};
            SIZE_HALF: lanes = {2{data[15:0]}};
            default:   lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection with sign or zero extension.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane, then extend it to 32 bits.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = 32'h0000_0000;
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SIZE_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: byte enables, load extension, misalign and bus-timeout traps.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_is_store,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_eff_addr,
    input  logic [1:0]  i_addr_exception,
    input  logic [31:0] i_store_data,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic        o_exc_valid,
    output logic [1:0]  o_exc_code,
    output logic [31:0] o_exc_addr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_addr;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic               r_is_store;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [1:0]         r_exc_code;
    logic [31:0]        r_wb_data;
    logic               w_accept;
    logic               w_timeout;
    logic               w_misaligned;
    logic [31:0]        w_load_data;

    assign w_misaligned = is_misaligned(i_size, i_addr_exception);

    mem_load_align u_load_align (
        .i_rdata    (i_dmem_rdata),
        .i_addr     (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an ack in the final REQ cycle beats the timeout.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_misaligned ? StResp : StReq;
                end
            end
            StReq: begin
                if (i_dmem_ack) begin
                    w_state_next = StResp;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operation latch, bus-side registers, wait counter and result capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_addr     <= 32'h0;
            r_size     <= SIZE_BYTE;
            r_unsigned <= 1'b0;
            r_is_store <= 1'b0;
            r_be       <= 4'h0;
            r_wdata    <= 32'h0;
            r_exc_code <= EXC_NONE;
            r_wb_data  <= 32'h0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_addr     <= i_eff_addr;
            r_size     <= i_size;
            r_unsigned <= i_unsigned;
            r_is_store <= i_is_store;
            r_be       <= byte_enables(i_size, i_eff_addr[1:0]);
            r_wdata    <= store_lanes(i_size, i_store_data);
            r_wb_data  <= 32'h0;
            if (w_misaligned) begin
                r_exc_code <= i_is_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
            end else begin
                r_exc_code <= EXC_NONE;
            end
        end else if (r_state == StReq) begin
            r_cnt <= r_cnt + 1'b1;
            if (i_dmem_ack) begin
                r_wb_data <= r_is_store ? 32'h0 : w_load_data;
            end else if (w_timeout) begin
                r_exc_code <= EXC_BUS_TIMEOUT;
            end
        end
    end

    assign o_ready      = (r_state == StIdle);
    assign o_dmem_req   = (r_state == StReq);
    assign o_dmem_we    = o_dmem_req & r_is_store;
    assign o_dmem_addr  = {r_addr[31:2], 2'b00};
    assign o_dmem_be    = r_be;
    assign o_dmem_wdata = r_wdata;
    assign o_wb_valid   = (r_state == StResp) && (r_exc_code == EXC_NONE);
    assign o_wb_data    = r_wb_data;
    assign o_exc_valid  = (r_state == StResp) && (r_exc_code != EXC_NONE);
    assign o_exc_code   = o_exc_valid ? r_exc_code : EXC_NONE;
    assign o_exc_addr   = r_addr;

endmodule
